// File: rtl/dom_rand_gen.sv
// dom_rand_gen: fresh-randomness source for DOM AND gadgets.
// A seeded 64-bit maximal-length LFSR emits one bit per step. The bits are
// packed MSB-first into RW-bit refresh words, which leave on a valid/ready
// handshake. Every accepted word is used exactly once.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   seed_i        - 64-bit LFSR seed; zero is replaced by 64'h1
//   seed_valid_i  - load seed_i this edge (highest priority)
//   rdi_o         - refresh word (all zeros while not valid)
//   rdi_valid_o   - rdi_o holds an unconsumed word
//   rdi_ready_i   - consumer accepts the word this edge
//   seeded_o      - a seed has been loaded since reset
module dom_rand_gen #(
  parameter int D  = 2,
  parameter int W  = 1,
  parameter int Z  = D*(D-1)/2,
  parameter int RW = Z*W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [63:0]   seed_i,
  input  logic          seed_valid_i,
  output logic [RW-1:0] rdi_o,
  output logic          rdi_valid_o,
  input  logic          rdi_ready_i,
  output logic          seeded_o
);

  localparam int CW = (RW > 1) ? $clog2(RW) : 1;

  typedef enum logic {UNSEEDED, RUN} state_t;

  state_t        state;
  logic [63:0]   s;
  logic [CW-1:0] cnt;
  logic [RW-1:0] acc;
  logic [RW-1:0] out;
  logic          full;

  logic          fb;
  logic          last;
  logic          step;
  logic          done;
  logic          consume;
  logic [RW-1:0] word;

  assign fb      = s[63] ^ s[62] ^ s[60] ^ s[59];
  assign last    = (cnt == CW'(RW-1));
  // Only the word-completing step can stall: it would overwrite a word the
  // consumer has not taken yet. All earlier steps keep filling acc.
  assign step    = (state == RUN) && !(last && full && !rdi_ready_i);
  assign done    = step && last;
  assign consume = full && rdi_ready_i;
  // Shift fb in from the LSB; truncation drops the oldest bit, which also
  // covers RW=1 where the word is just fb.
  assign word    = RW'({acc, fb});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UNSEEDED;
      s        <= '0;
      cnt      <= '0;
      acc      <= '0;
      out      <= '0;
      full     <= 1'b0;
      seeded_o <= 1'b0;
    end else if (seed_valid_i) begin
      // Reseed discards any pending word, even one being accepted now.
      state    <= RUN;
      s        <= (seed_i == 64'd0) ? 64'd1 : seed_i;
      cnt      <= '0;
      acc      <= '0;
      out      <= '0;
      full     <= 1'b0;
      seeded_o <= 1'b1;
    end else if (state == RUN) begin
      if (step) begin
        s   <= {s[62:0], fb};
        acc <= word;
        cnt <= last ? '0 : cnt + CW'(1);
      end
      // A completion on the consuming edge replaces the taken word directly.
      if (done) begin
        out  <= word;
        full <= 1'b1;
      end else if (consume) begin
        out  <= '0;
        full <= 1'b0;
      end
    end
  end

  // out is cleared whenever full drops, so it already reads zero when empty.
  assign rdi_o       = out;
  assign rdi_valid_o = full;

endmodule

// File: tb/tb_dom_rand_gen.sv
// Bench for dom_rand_gen: an RW=1 instance (D=2,W=1) and an RW=12 instance
// (D=3,W=4) checked against a bit-stream reference model.
module tb_dom_rand_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] seed_a, seed_b;
  logic        sv_a, sv_b, rdy_a, rdy_b;
  logic [0:0]  rdi_a;
  logic [11:0] rdi_b;
  logic        va, vb, sa, sb;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] ms;

  always #5 clk = ~clk;

  dom_rand_gen #(.D(2), .W(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .seed_i(seed_a), .seed_valid_i(sv_a),
    .rdi_o(rdi_a), .rdi_valid_o(va), .rdi_ready_i(rdy_a), .seeded_o(sa)
  );

  dom_rand_gen #(.D(3), .W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .seed_i(seed_b), .seed_valid_i(sv_b),
    .rdi_o(rdi_b), .rdi_valid_o(vb), .rdi_ready_i(rdy_b), .seeded_o(sb)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Reference stream: the LFSR as a bit source, words are the next rw bits
  // taken in order, first bit in the word MSB.
  task automatic next_word(input int rw, output logic [63:0] w);
    logic b;
    w = '0;
    for (int i = 0; i < rw; i++) begin
      b  = ms[63] ^ ms[62] ^ ms[60] ^ ms[59];
      ms = {ms[62:0], b};
      w  = {w[62:0], b};
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_va"}, 64'(va), 64'd0);
    chk({tag, "_rdi_a"}, 64'(rdi_a), 64'd0);
    chk({tag, "_sa"}, 64'(sa), 64'd0);
    chk({tag, "_vb"}, 64'(vb), 64'd0);
    chk({tag, "_rdi_b"}, 64'(rdi_b), 64'd0);
    chk({tag, "_sb"}, 64'(sb), 64'd0);
  endtask

  // Random-ready run on one instance (sel=1 selects the RW=12 one).
  task automatic bp(input bit sel, input int nwords, input logic [63:0] seed);
    int          rw, got_words, cyc;
    bit          pending;
    logic        v, rd;
    logic [63:0] r, held;
    rw = sel ? 12 : 1;
    if (sel) begin seed_b = seed; sv_b = 1'b1; end
    else     begin seed_a = seed; sv_a = 1'b1; end
    step_clk();
    sv_a = 1'b0; sv_b = 1'b0;
    ms = (seed == 64'd0) ? 64'd1 : seed;
    pending = 0; got_words = 0; cyc = 0; held = '0;
    while (got_words < nwords && cyc < nwords*40 + 100) begin
      if (cyc > 0) step_clk();
      cyc++;
      v = sel ? vb : va;
      r = sel ? 64'(rdi_b) : 64'(rdi_a);
      if (v) begin
        if (pending) chk("bp_stable", r, held);
        else begin
          next_word(rw, held);
          chk("bp_word", r, held);
          pending = 1;
        end
      end else if (pending) begin
        chk("bp_valid_hold", 64'(v), 64'd1);
      end
      rd = 1'($urandom_range(0, 1));
      if (sel) rdy_b = rd; else rdy_a = rd;
      if (v && rd) begin
        pending = 0;
        got_words++;
      end
    end
    chk("bp_count", 64'(got_words), 64'(nwords));
    step_clk();
  endtask

  initial begin
    logic [63:0] w, w1, nseed;
    rst_n = 1'b0;
    seed_a = '0; seed_b = '0; sv_a = 1'b0; sv_b = 1'b0;
    rdy_a = 1'b1; rdy_b = 1'b1;
    ms = '0;
    #3;
    chk_all_zero("reset");
    repeat (2) step_clk();
    rst_n = 1'b1;

    // Unseeded: nothing may come out.
    for (int i = 0; i < 100; i++) begin
      step_clk();
      chk_all_zero("unseeded");
    end

    // Known-answer stream, RW=1, seed 1.
    seed_a = 64'd1; sv_a = 1'b1;
    step_clk();
    sv_a = 1'b0;
    chk("kat_seeded", 64'(sa), 64'd1);
    chk("kat_valid_e0", 64'(va), 64'd0);
    ms = 64'd1;
    for (int i = 1; i <= 10000; i++) begin
      step_clk();
      next_word(1, w);
      chk("kat_valid", 64'(va), 64'd1);
      chk("kat_word", 64'(rdi_a), w);
      if (i < 60) chk("kat_early_zero", 64'(rdi_a), 64'd0);
      if (i == 60) chk("kat_word60", 64'(rdi_a), 64'd1);
    end

    // Zero seed behaves as seed 1.
    seed_a = 64'd0; sv_a = 1'b1;
    step_clk();
    sv_a = 1'b0;
    chk("zs_valid_drop", 64'(va), 64'd0);
    chk("zs_seeded", 64'(sa), 64'd1);
    ms = 64'd1;
    for (int i = 1; i <= 200; i++) begin
      step_clk();
      next_word(1, w);
      chk("zs_word", 64'(rdi_a), w);
      if (i == 60) chk("zs_word60", 64'(rdi_a), 64'd1);
    end

    // Multi-bit assembly, RW=12, ready held high.
    nseed = {$urandom, $urandom} | 64'd1;
    seed_b = nseed; sv_b = 1'b1;
    step_clk();
    sv_b = 1'b0;
    chk("mb_valid_e0", 64'(vb), 64'd0);
    ms = nseed;
    for (int n = 0; n < 20; n++) begin
      for (int c = 1; c <= 12; c++) begin
        step_clk();
        chk("mb_valid", 64'(vb), 64'(c == 12));
        if (c == 12) begin
          next_word(12, w);
          chk("mb_word", 64'(rdi_b), w);
        end
      end
    end

    // Backpressure.
    bp(1'b0, 5000, {$urandom, $urandom});
    bp(1'b1, 300, {$urandom, $urandom} | 64'd1);

    // Reseed with a full word pending and cnt=5.
    rdy_b = 1'b0;
    nseed = {$urandom, $urandom} | 64'd2;
    seed_b = nseed; sv_b = 1'b1;
    step_clk();
    sv_b = 1'b0;
    ms = nseed;
    next_word(12, w1);
    repeat (17) step_clk();
    chk("rs_full_before", 64'(vb), 64'd1);
    chk("rs_held_word", 64'(rdi_b), w1);
    rdy_b = 1'b1;
    nseed = {$urandom, $urandom} | 64'd4;
    seed_b = nseed; sv_b = 1'b1;
    step_clk();
    sv_b = 1'b0;
    chk("rs_valid_drop", 64'(vb), 64'd0);
    chk("rs_rdi_zero", 64'(rdi_b), 64'd0);
    ms = nseed;
    for (int c = 1; c <= 12; c++) begin
      step_clk();
      chk("rs_valid", 64'(vb), 64'(c == 12));
    end
    next_word(12, w);
    chk("rs_first_word", 64'(rdi_b), w);

    // Asynchronous reset mid-word with a word pending.
    rdy_b = 1'b0;
    repeat (5) step_clk();
    chk("ar_valid_before", 64'(vb), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
